// File: rtl/bram_sdp_be.sv
// bram_sdp_be: simple-dual-port block RAM with byte-lane write enables,
// selectable read-during-write behaviour and an optional output register.
//   clk          rising-edge clock for all logic
//   rst          synchronous active-high reset (output path only, not memory)
//   wr_en_i      write request
//   wr_addr_i    write address
//   wr_be_i      byte-lane write enables, bit k covers din_i[k*BYTE_WIDTH +: BYTE_WIDTH]
//   din_i        write data
//   rd_en_i      read request
//   rd_addr_i    read address
//   dout_o       read data, holds last result until the next read completes
//   dout_valid_o one-cycle pulse when dout_o carries a new read result
module bram_sdp_be #(
    parameter int RAM_WIDTH  = 16,
    parameter int RAM_DEPTH  = 1024,
    parameter int BYTE_WIDTH = 8,
    parameter int OUT_REG    = 1,
    parameter int RDW_MODE   = 0,
    localparam int ADDR_WIDTH = $clog2(RAM_DEPTH),
    localparam int NB_LANES   = RAM_WIDTH / BYTE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [NB_LANES-1:0]   wr_be_i,
    input  logic [RAM_WIDTH-1:0]  din_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [RAM_WIDTH-1:0]  dout_o,
    output logic                  dout_valid_o
);
    if (RAM_WIDTH % BYTE_WIDTH != 0 || (OUT_REG != 0 && OUT_REG != 1)) begin : g_bad_cfg
        $error("bram_sdp_be: RAM_WIDTH must be a multiple of BYTE_WIDTH and OUT_REG must be 0 or 1");
    end

    // One extra bit so the depth itself is representable for the range check.
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(RAM_DEPTH);

    logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
    logic                 wr_ok;
    logic                 rd_in_range;
    logic [RAM_WIDTH-1:0] rd_word;
    logic [RAM_WIDTH-1:0] merged;
    logic [RAM_WIDTH-1:0] rd_sel;
    logic [RAM_WIDTH-1:0] s1_data_q, s1_data_d;
    logic                 s1_valid_q, s1_valid_d;

    assign wr_ok       = wr_en_i && ({1'b0, wr_addr_i} < DEPTH_L);
    assign rd_in_range = {1'b0, rd_addr_i} < DEPTH_L;

    // No reset on the array so synthesis maps it onto block RAM.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok) begin
            for (int k = 0; k < NB_LANES; k++) begin
                if (wr_be_i[k]) mem[wr_addr_i][k*BYTE_WIDTH +: BYTE_WIDTH] <= din_i[k*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // Write-first collisions return the old word with the enabled lanes replaced.
    always_comb begin
        rd_word = rd_in_range ? mem[rd_addr_i] : '0;
        merged  = rd_word;
        for (int k = 0; k < NB_LANES; k++) begin
            if (wr_be_i[k]) merged[k*BYTE_WIDTH +: BYTE_WIDTH] = din_i[k*BYTE_WIDTH +: BYTE_WIDTH];
        end
        rd_sel     = (RDW_MODE == 1 && wr_ok && rd_in_range && wr_addr_i == rd_addr_i) ? merged : rd_word;
        s1_data_d  = rd_en_i ? rd_sel : s1_data_q;
        s1_valid_d = rd_en_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_data_q  <= '0;
            s1_valid_q <= 1'b0;
        end else begin
            s1_data_q  <= s1_data_d;
            s1_valid_q <= s1_valid_d;
        end
    end

    if (OUT_REG == 1) begin : g_oreg
        logic [RAM_WIDTH-1:0] s2_data_q, s2_data_d;
        logic                 s2_valid_q;
        assign s2_data_d = s1_valid_q ? s1_data_q : s2_data_q;
        always_ff @(posedge clk) begin
            if (rst) begin
                s2_data_q  <= '0;
                s2_valid_q <= 1'b0;
            end else begin
                s2_data_q  <= s2_data_d;
                s2_valid_q <= s1_valid_q;
            end
        end
        assign dout_o       = s2_data_q;
        assign dout_valid_o = s2_valid_q;
    end else begin : g_noreg
        assign dout_o       = s1_data_q;
        assign dout_valid_o = s1_valid_q;
    end
endmodule

// File: tb/tb_bram_sdp_be.sv
// tb_bram_sdp_be: table-driven scoreboard bench for two bram_sdp_be configurations.
module tb_bram_sdp_be;
    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [1:0]  wr_be;
    logic [15:0] din;
    logic        rd_en;
    logic [9:0]  rd_addr;
    logic [15:0] dout0, dout1;
    logic        v0, v1;

    always #5 clk = ~clk;

    // DUT 0: defaults (1024 deep, OUT_REG=1, read-first)
    bram_sdp_be u_dut0 (
        .clk(clk), .rst(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_be_i(wr_be),
        .din_i(din), .rd_en_i(rd_en), .rd_addr_i(rd_addr), .dout_o(dout0), .dout_valid_o(v0)
    );

    // DUT 1: 1000 deep, OUT_REG=0, write-first
    bram_sdp_be #(.RAM_DEPTH(1000), .OUT_REG(0), .RDW_MODE(1)) u_dut1 (
        .clk(clk), .rst(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_be_i(wr_be),
        .din_i(din), .rd_en_i(rd_en), .rd_addr_i(rd_addr), .dout_o(dout1), .dout_valid_o(v1)
    );

    typedef struct {
        logic        we;
        int          wa;
        logic [1:0]  be;
        logic [15:0] d;
        logic        re;
        int          ra;
        logic [15:0] e0;
        logic [15:0] e1;
    } vec_t;

    typedef struct {
        int          due;
        logic [15:0] d;
    } exp_t;

    exp_t        q [2][$];
    logic [15:0] last_d [2];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    task automatic cmp(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, req);
        end
    endtask

    task automatic chk_port(input int p, input logic [15:0] d, input logic v);
        exp_t e;
        if (v) begin
            if (q[p].size() == 0) begin
                total++;
                bad++;
                $display("FAIL dut%0d unexpected valid at cycle %0d: got 0x%0h, expected no valid", p, cyc, d);
            end else begin
                e = q[p].pop_front();
                cmp($sformatf("dut%0d latency", p), cyc, e.due);
                cmp($sformatf("dut%0d data", p), d, e.d);
                last_d[p] = e.d;
            end
        end else begin
            cmp($sformatf("dut%0d hold", p), d, last_d[p]);
            if (q[p].size() > 0 && q[p][0].due <= cyc) begin
                e = q[p].pop_front();
                total++;
                bad++;
                $display("FAIL dut%0d missing valid at cycle %0d: got none, expected 0x%0h", p, cyc, e.d);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        chk_port(0, dout0, v0);
        chk_port(1, dout1, v1);
    endtask

    function automatic vec_t mk(input logic we, input int wa, input logic [1:0] be, input logic [15:0] d,
                                input logic re, input int ra, input logic [15:0] e0, input logic [15:0] e1);
        vec_t v;
        v.we = we; v.wa = wa; v.be = be; v.d = d; v.re = re; v.ra = ra; v.e0 = e0; v.e1 = e1;
        return v;
    endfunction

    task automatic push(input int p, input int lat, input logic [15:0] d);
        exp_t e;
        e.due = cyc + lat;
        e.d   = d;
        q[p].push_back(e);
    endtask

    initial begin
        vec_t tbl[$];
        tbl.push_back(mk(1, 0,    2'b11, 16'hABCD, 0, 0,    0,        0));
        tbl.push_back(mk(0, 0,    2'b00, 16'h0000, 1, 0,    16'hABCD, 16'hABCD));
        tbl.push_back(mk(0, 0,    2'b00, 16'h0000, 0, 0,    0,        0));
        tbl.push_back(mk(0, 0,    2'b00, 16'h0000, 0, 0,    0,        0));
        tbl.push_back(mk(1, 5,    2'b11, 16'h1234, 0, 0,    0,        0));
        tbl.push_back(mk(1, 5,    2'b01, 16'h00FF, 0, 0,    0,        0));
        tbl.push_back(mk(0, 0,    2'b00, 16'h0000, 1, 5,    16'h12FF, 16'h12FF));
        tbl.push_back(mk(1, 5,    2'b10, 16'hAB00, 0, 0,    0,        0));
        tbl.push_back(mk(0, 0,    2'b00, 16'h0000, 1, 5,    16'hABFF, 16'hABFF));
        tbl.push_back(mk(1, 7,    2'b11, 16'h1111, 0, 0,    0,        0));
        tbl.push_back(mk(1, 7,    2'b11, 16'h2222, 1, 7,    16'h1111, 16'h2222));
        tbl.push_back(mk(0, 0,    2'b00, 16'h0000, 1, 7,    16'h2222, 16'h2222));
        tbl.push_back(mk(1, 7,    2'b01, 16'h00AA, 1, 7,    16'h2222, 16'h22AA));
        tbl.push_back(mk(0, 0,    2'b00, 16'h0000, 1, 7,    16'h22AA, 16'h22AA));
        tbl.push_back(mk(1, 9,    2'b11, 16'h1357, 0, 0,    0,        0));
        tbl.push_back(mk(1, 9,    2'b00, 16'hFFFF, 0, 0,    0,        0));
        tbl.push_back(mk(0, 0,    2'b00, 16'h0000, 1, 9,    16'h1357, 16'h1357));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(1, i, 2'b11, 16'hA000 + 16'(i), 0, 0, 0, 0));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 2'b00, 0, 1, i, 16'hA000 + 16'(i), 16'hA000 + 16'(i)));
        tbl.push_back(mk(1, 3,    2'b11, 16'hBEEF, 1, 2,    16'hA002, 16'hA002));
        tbl.push_back(mk(1, 1010, 2'b11, 16'h5555, 0, 0,    0,        0));
        tbl.push_back(mk(0, 0,    2'b00, 16'h0000, 1, 1010, 16'h5555, 16'h0000));
        tbl.push_back(mk(1, 999,  2'b11, 16'h7777, 0, 0,    0,        0));
        tbl.push_back(mk(0, 0,    2'b00, 16'h0000, 1, 999,  16'h7777, 16'h7777));
        tbl.push_back(mk(1, 0,    2'b11, 16'hABCD, 0, 0,    0,        0));
        tbl.push_back(mk(0, 0,    2'b00, 16'h0000, 1, 0,    16'hABCD, 16'hABCD));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 2'b00, 0, 0, 0, 0, 0));

        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_be = '0; din = '0; rd_en = 1'b0; rd_addr = '0;
        last_d[0] = '0;
        last_d[1] = '0;
        tick();
        tick();
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            wr_en = tbl[i].we; wr_addr = 10'(tbl[i].wa); wr_be = tbl[i].be; din = tbl[i].d;
            rd_en = tbl[i].re; rd_addr = 10'(tbl[i].ra);
            if (tbl[i].re) begin
                push(0, 2, tbl[i].e0);
                push(1, 1, tbl[i].e1);
            end
            tick();
        end

        // Read in flight on DUT 0 when reset hits; DUT 1 has already delivered it.
        wr_en = 1'b0; rd_en = 1'b1; rd_addr = 10'd0;
        push(1, 1, 16'hABCD);
        tick();
        // Reset cycle: write and read requests must be ignored.
        rst = 1'b1; wr_en = 1'b1; wr_addr = 10'd0; wr_be = 2'b11; din = 16'hDEAD; rd_en = 1'b1;
        q[0].delete();
        q[1].delete();
        last_d[0] = '0;
        last_d[1] = '0;
        tick();
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        tick();
        tick();
        rd_en = 1'b1; rd_addr = 10'd0;
        push(0, 2, 16'hABCD);
        push(1, 1, 16'hABCD);
        tick();
        rd_en = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        cmp("dut0 drained", q[0].size(), 0);
        cmp("dut1 drained", q[1].size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bram_sdp_be.md
Name: bram_sdp_be

Overview:
- Parametrised simple-dual-port block RAM: one write port and one independent read port on a single clock.
- Generalises the single-port BRAM with three additions:
  - per-byte write enables;
  - selectable read-during-write behaviour;
  - optional output pipeline register with a read-valid flag.
- Used as the storage primitive behind line buffers, FIFOs and coefficient tables that need concurrent read and write.

Parameters:
- RAM_WIDTH, 16: data word width in bits; must be a multiple of BYTE_WIDTH.
- RAM_DEPTH, 1024: number of words; need not be a power of two.
- BYTE_WIDTH, 8: bits per write-enable lane.
- OUT_REG, 1: 0 gives read latency 1; 1 adds an output register, giving read latency 2.
- RDW_MODE, 0: same-address read-during-write result; 0 returns old data (read-first), 1 returns new data (write-first).
- Derived localparam ADDR_WIDTH = $clog2(RAM_DEPTH).
- Derived localparam NB_LANES = RAM_WIDTH/BYTE_WIDTH.

Ports:
- clk  in  1  rising-edge clock for all logic.
- rst  in  1  synchronous, active-high reset.
- wr_en_i  in  1  write request.
- wr_addr_i  in  ADDR_WIDTH  write address.
- wr_be_i  in  NB_LANES  byte-lane write enables; bit k covers din_i[k*BYTE_WIDTH +: BYTE_WIDTH].
- din_i  in  RAM_WIDTH  write data.
- rd_en_i  in  1  read request.
- rd_addr_i  in  ADDR_WIDTH  read address.
- dout_o  out  RAM_WIDTH  read data.
- dout_valid_o  out  1  high for exactly one cycle when dout_o carries the result of a read.

Behaviour:
- Reset (rst sampled high at a clock edge):
  - dout_o = 0 and dout_valid_o = 0, including the internal stage-1 data and valid registers.
  - Any reads in flight are discarded and produce no valid pulse.
  - Memory contents are not cleared.
  - wr_en_i and rd_en_i are ignored while rst is high.
- Write:
  - On a rising edge with wr_en_i=1, rst=0 and wr_addr_i < RAM_DEPTH, each lane k with wr_be_i[k]=1 is updated from din_i.
  - Lanes with wr_be_i[k]=0 keep their previous contents.
  - wr_be_i = 0 with wr_en_i = 1 performs no write.
- Read, stage 1:
  - On an edge with rd_en_i=1 and rst=0, the word at rd_addr_i is captured into the stage-1 register and the stage-1 valid flag is set.
  - With rd_en_i=0, the stage-1 data register holds its value and the stage-1 valid flag clears.
- OUT_REG=0:
  - dout_o and dout_valid_o are driven directly from stage 1.
  - Latency is 1: a request at edge N gives data after edge N, valid in cycle N+1.
- OUT_REG=1:
  - The stage-2 data register loads from stage 1 only when the stage-1 valid flag is high.
  - The stage-2 valid register follows the stage-1 valid flag every cycle.
  - Latency is 2 cycles.
- Throughput: one read per cycle. Back-to-back reads give consecutive valid cycles.
- Hold: dout_o holds the last read result indefinitely when no read is issued. Only dout_valid_o drops.
- Read-during-write collision (rd_en_i=1, wr_en_i=1, rd_addr_i == wr_addr_i, same edge):
  - RDW_MODE=0: the read returns the word as it was before the write.
  - RDW_MODE=1: the read returns the merged word, with enabled lanes from din_i and the other lanes unchanged.
  - Different addresses never interact.
- Out of range (address >= RAM_DEPTH, possible only when RAM_DEPTH is not a power of two):
  - A write is ignored.
  - A read returns 0 with dout_valid_o asserted normally.
- Reset and memory: a write or read issued in the cycle that rst deasserts (rst=0 at that edge) is honoured normally.
- Elaboration: the block fails elaboration if RAM_WIDTH % BYTE_WIDTH != 0 or OUT_REG is not in {0,1}.
- Inference: no reset on the memory array, so it infers block RAM.

Test Plan:
- Defaults (16x1024, OUT_REG=1, RDW_MODE=0):
  - Write 0xABCD to addr 0 with be=2'b11, then read addr 0.
  - Required: dout_o=0xABCD two cycles after rd_en_i, dout_valid_o high for exactly one cycle, then dout_o holds 0xABCD with valid low.
- Byte enables:
  - Write 0x1234 to addr 5 with be=11, write 0x00FF to addr 5 with be=01, then read addr 5.
  - Required: 0x12FF.
  - Repeat with be=10 and data 0xAB00. Required: 0xABFF.
- Collision:
  - With addr 7 holding 0x1111, write 0x2222 (be=11) and read addr 7 on the same edge.
  - RDW_MODE=0 returns 0x1111; RDW_MODE=1 returns 0x2222. A following read returns 0x2222 in both modes.
- Streaming with OUT_REG=0:
  - Preload addrs 0..3 with 0xA000..0xA003, then assert rd_en_i for 4 consecutive cycles on addrs 0..3.
  - Required: 4 consecutive valid cycles carrying 0xA000..0xA003, each 1 cycle after its request.
- Reset mid-read (OUT_REG=1):
  - Issue a read of addr 0 (holding 0xABCD), assert rst the next cycle for 1 cycle.
  - Required: dout_o=0, no valid pulse.
  - After reset, read addr 0. Required: 0xABCD, showing memory is preserved.
- Non-power-of-two depth (RAM_DEPTH=1000):
  - Write 0x5555 to addr 1010, then read addr 1010.
  - Required: dout_o=0 with valid high.
  - Addr 999 still writes and reads correctly with 0x7777.
